window_fetch: RTL and testbench
===============================

WINDOW_FETCH -- requirements
Module: window_fetch

Interface
REQ-001 Parameter H_WINDOW_LEN, default 5: window width in pixels.
REQ-002 Parameter V_WINDOW_LEN, default 5: window height in pixels.
REQ-003 Parameter H_IMAGE_LEN, default 30: image row pitch in words.
REQ-004 Parameter V_IMAGE_LEN, default 30: image height in rows.
REQ-005 Parameter DATA_W, default 8: pixel width.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 anchor_valid  in  1  anchor_addr valid.
REQ-010 anchor_ready  out  1  block accepts an anchor.
REQ-011 anchor_addr  in  32  top-left image address of the window.
REQ-012 ram_rd_en  out  1  image RAM read strobe.
REQ-013 ram_rd_addr  out  32  image RAM read address.
REQ-014 ram_rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after ram_rd_en.
REQ-015 win_valid  out  1  window output valid.
REQ-016 win_ready  in  1  consumer accepts window.
REQ-017 win_data  out  H_WINDOW_LEN*V_WINDOW_LEN*DATA_W  packed window pixels.
REQ-018 win_anchor  out  32  anchor of the window on win_data.
REQ-019 frame_last  out  1  marks the last window of a frame; qualified by win_valid.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DRAIN, OUT; anchor_ready SHALL be 1 only in IDLE.
REQ-021 IDLE -> FETCH on anchor_valid&&anchor_ready; anchor_addr latched; indices h=0, v=0.
REQ-022 In FETCH, ram_rd_en=1 every cycle; ram_rd_addr = anchor + h + v*H_IMAGE_LEN, mod 2^32, no bounds check.
REQ-023 Issue order: h increments; at h=H_WINDOW_LEN-1, h wraps to 0 and v increments; after (h,v)=(H_WINDOW_LEN-1,V_WINDOW_LEN-1), FETCH -> DRAIN.
REQ-024 Slot k=v*H_WINDOW_LEN+h SHALL occupy win_data[DATA_W*(k+1)-1 : DATA_W*k], written from ram_rd_data the cycle after issuing k.
REQ-025 DRAIN lasts 1 cycle, captures the last slot, then -> OUT; ram_rd_en=0 outside FETCH.
REQ-026 OUT: win_valid=1; win_data, win_anchor, frame_last stable until win_valid&&win_ready, then -> IDLE.
REQ-027 Latency: acceptance in cycle T -> first read T+1, last read T+25, win_valid first high T+27 (defaults).
REQ-028 Minimum anchor-to-anchor period 28 cycles; no overlap of fetches.
REQ-029 Window counter 0..(H_IMAGE_LEN-H_WINDOW_LEN+1)*(V_IMAGE_LEN-V_WINDOW_LEN+1)-1 (0..675 default); frame_last=1 while counter is at max in OUT.
REQ-030 Counter increments on each win handshake and wraps to 0 after the max-count handshake.
REQ-031 anchor_valid outside IDLE SHALL be ignored, not latched.
REQ-032 win_data retains its last contents after handshake until overwritten.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, counter 0, h=v=0, win_data 0, win_anchor 0.
REQ-034 Output reset values: anchor_ready 1, ram_rd_en 0, ram_rd_addr 0, win_valid 0, frame_last 0.
REQ-035 Reset mid-FETCH/DRAIN/OUT abandons the window; ram_rd_data in the cycle after reset is discarded.

Verification
REQ-036 Anchor 0, RAM mem[a]=a[7:0] -> ram_rd_addr 0,1,2,3,4,30..34,...,120..124; slot k = that address; win_valid at T+27, win_anchor 0.
REQ-037 Anchor 775 -> last ram_rd_addr 899; slot 24 = mem[899].
REQ-038 win_ready low 10 cycles in OUT -> win_valid stays 1, win_data stable, anchor_ready 0, ram_rd_en 0.
REQ-039 anchor_valid held high, anchors 0 then 1, win_ready=1 -> second accepted exactly 1 cycle after the first win handshake.
REQ-040 rst pulse while issuing k=12 -> next cycle IDLE, all outputs at reset values; anchor 31 then yields correct window.
REQ-041 676 windows -> frame_last=1 only on the 676th; the 677th has frame_last=0.

Source files
------------

// File: rtl/window_fetch_if.sv
// Bundles the anchor handshake, image RAM read port and window output handshake
// used by window_fetch. The master side is the fetch engine; the slave side is
// the surrounding system (anchor source, image RAM and window consumer).
interface window_fetch_if #(
    parameter int DATA_W   = 8,
    parameter int WIN_BITS = 200
);
    logic                anchor_valid;
    logic                anchor_ready;
    logic [31:0]         anchor_addr;
    logic                ram_rd_en;
    logic [31:0]         ram_rd_addr;
    logic [DATA_W-1:0]   ram_rd_data;
    logic                win_valid;
    logic                win_ready;
    logic [WIN_BITS-1:0] win_data;
    logic [31:0]         win_anchor;
    logic                frame_last;

    modport master (
        input  anchor_valid, anchor_addr, ram_rd_data, win_ready,
        output anchor_ready, ram_rd_en, ram_rd_addr, win_valid, win_data, win_anchor, frame_last
    );

    modport slave (
        output anchor_valid, anchor_addr, ram_rd_data, win_ready,
        input  anchor_ready, ram_rd_en, ram_rd_addr, win_valid, win_data, win_anchor, frame_last
    );
endinterface

// File: rtl/window_fetch.sv
// Window fetch engine: accepts a top-left anchor address, reads an
// H_WINDOW_LEN x V_WINDOW_LEN block of pixels from an image RAM with one-cycle
// read latency, packs them row-major into win_data and presents the window
// through a valid/ready handshake. A running window counter flags the last
// window of a frame on frame_last.
module window_fetch #(
    parameter int H_WINDOW_LEN = 5,
    parameter int V_WINDOW_LEN = 5,
    parameter int H_IMAGE_LEN  = 30,
    parameter int V_IMAGE_LEN  = 30,
    parameter int DATA_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    window_fetch_if.master bus
);
    localparam int NUM_PIX  = H_WINDOW_LEN * V_WINDOW_LEN;
    localparam int WIN_BITS = NUM_PIX * DATA_W;
    localparam int NUM_WIN  = (H_IMAGE_LEN - H_WINDOW_LEN + 1) * (V_IMAGE_LEN - V_WINDOW_LEN + 1);
    localparam int HW       = (H_WINDOW_LEN > 1) ? $clog2(H_WINDOW_LEN) : 1;
    localparam int VW       = (V_WINDOW_LEN > 1) ? $clog2(V_WINDOW_LEN) : 1;
    localparam int KW       = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int CW       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(H_WINDOW_LEN - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_WINDOW_LEN - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_WIN - 1);
    localparam logic [31:0]   PITCH     = 32'(H_IMAGE_LEN);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT
    } state_t;

    state_t              state;
    logic [HW-1:0]       h;
    logic [VW-1:0]       v;
    logic [KW-1:0]       k;
    logic [31:0]         row_addr;
    logic                cap_pending;
    logic [KW-1:0]       cap_slot;
    logic [CW-1:0]       win_count;

    logic                anchor_ready;
    logic                rd_en;
    logic [31:0]         rd_addr;
    logic                win_valid;
    logic [WIN_BITS-1:0] win_data;
    logic [31:0]         win_anchor;
    logic                frame_last;

    assign bus.anchor_ready = anchor_ready;
    assign bus.ram_rd_en    = rd_en;
    assign bus.ram_rd_addr  = rd_addr;
    assign bus.win_valid    = win_valid;
    assign bus.win_data     = win_data;
    assign bus.win_anchor   = win_anchor;
    assign bus.frame_last   = frame_last;

    // Sequencer: issues one read per FETCH cycle, captures each returning pixel
    // one cycle later into its slot, then holds the window until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            h            <= '0;
            v            <= '0;
            k            <= '0;
            row_addr     <= '0;
            cap_pending  <= 1'b0;
            cap_slot     <= '0;
            win_count    <= '0;
            anchor_ready <= 1'b1;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            win_valid    <= 1'b0;
            win_data     <= '0;
            win_anchor   <= '0;
            frame_last   <= 1'b0;
        end else begin
            cap_pending <= 1'b0;
            if (cap_pending) begin
                win_data[int'(cap_slot)*DATA_W +: DATA_W] <= bus.ram_rd_data;
            end

            case (state)
                IDLE: begin
                    if (bus.anchor_valid) begin
                        state        <= FETCH;
                        anchor_ready <= 1'b0;
                        win_anchor   <= bus.anchor_addr;
                        row_addr     <= bus.anchor_addr;
                        rd_addr      <= bus.anchor_addr;
                        rd_en        <= 1'b1;
                        h            <= '0;
                        v            <= '0;
                        k            <= '0;
                    end
                end
                FETCH: begin
                    cap_pending <= 1'b1;
                    cap_slot    <= k;
                    k           <= k + 1'b1;
                    if (h == H_LAST) begin
                        h <= '0;
                        if (v == V_LAST) begin
                            v     <= '0;
                            rd_en <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            v        <= v + 1'b1;
                            row_addr <= row_addr + PITCH;
                            rd_addr  <= row_addr + PITCH;
                        end
                    end else begin
                        h       <= h + 1'b1;
                        rd_addr <= rd_addr + 32'd1;
                    end
                end
                DRAIN: begin
                    state      <= OUT;
                    win_valid  <= 1'b1;
                    frame_last <= (win_count == COUNT_MAX);
                end
                OUT: begin
                    if (bus.win_ready) begin
                        state        <= IDLE;
                        win_valid    <= 1'b0;
                        frame_last   <= 1'b0;
                        anchor_ready <= 1'b1;
                        win_count    <= (win_count == COUNT_MAX) ? '0 : win_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_fetch.sv
// Self-checking bench for window_fetch: a behavioural image RAM answers reads,
// and every window is compared against one rebuilt from the anchor address.
module tb_window_fetch;
    localparam int H_WIN    = 5;
    localparam int V_WIN    = 5;
    localparam int H_IMG    = 30;
    localparam int V_IMG    = 30;
    localparam int DATA_W   = 8;
    localparam int WIN_BITS = H_WIN * V_WIN * DATA_W;
    localparam int NUM_PIX  = H_WIN * V_WIN;
    localparam int NUM_WIN  = (H_IMG - H_WIN + 1) * (V_IMG - V_WIN + 1);

    logic clk;
    logic rst;
    int   cyc;
    int   tests_run;
    int   tests_failed;
    int   win_idx;

    logic [31:0]       rd_addr_q[$];
    int                rd_cyc_q[$];
    logic [DATA_W-1:0] ram_next;

    window_fetch_if #(.DATA_W(DATA_W), .WIN_BITS(WIN_BITS)) bus ();

    window_fetch #(
        .H_WINDOW_LEN(H_WIN),
        .V_WINDOW_LEN(V_WIN),
        .H_IMAGE_LEN (H_IMG),
        .V_IMAGE_LEN (V_IMG),
        .DATA_W      (DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image contents as a pure function of the address.
    function automatic logic [DATA_W-1:0] mem_val(input logic [31:0] a);
        return a[7:0] ^ {a[14:8], 1'b0} ^ a[31:24];
    endfunction

    // Window expected for an anchor: row-major pixels, slot 0 in the low byte.
    function automatic logic [WIN_BITS-1:0] exp_window(input logic [31:0] anchor);
        logic [WIN_BITS-1:0] w;
        w = '0;
        for (int vv = 0; vv < V_WIN; vv++)
            for (int hh = 0; hh < H_WIN; hh++)
                w[(vv*H_WIN+hh)*DATA_W +: DATA_W] = mem_val(anchor + 32'(hh) + 32'(vv*H_IMG));
        return w;
    endfunction

    // Cycle counter, advanced on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Read monitor: log issued reads and prepare the RAM answer for the next cycle.
    always @(negedge clk) begin
        if (bus.ram_rd_en === 1'b1) begin
            rd_addr_q.push_back(bus.ram_rd_addr);
            rd_cyc_q.push_back(cyc);
            ram_next = mem_val(bus.ram_rd_addr);
        end else begin
            ram_next = DATA_W'($urandom);
        end
    end

    // Image RAM: data appears one cycle after the read strobe.
    always @(posedge clk) bus.ram_rd_data <= ram_next;

    // Runaway guard.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_output({pfx, "_anchor_ready"}, 256'(bus.anchor_ready), 256'(1'b1));
        check_output({pfx, "_ram_rd_en"},    256'(bus.ram_rd_en),    256'(1'b0));
        check_output({pfx, "_ram_rd_addr"},  256'(bus.ram_rd_addr),  256'(32'd0));
        check_output({pfx, "_win_valid"},    256'(bus.win_valid),    256'(1'b0));
        check_output({pfx, "_frame_last"},   256'(bus.frame_last),   256'(1'b0));
        check_output({pfx, "_win_data"},     256'(bus.win_data),     256'(0));
        check_output({pfx, "_win_anchor"},   256'(bus.win_anchor),   256'(32'd0));
    endtask

    // Present an anchor once the block is ready; returns the acceptance cycle.
    task automatic apply_stimulus(input logic [31:0] anchor, output int t_acc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.anchor_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("anchor_ready_wait", 256'(seen), 256'(1'b1));
        bus.anchor_valid = 1'b1;
        bus.anchor_addr  = anchor;
        t_acc = cyc;
        @(negedge clk);
        bus.anchor_valid = 1'b0;
    endtask

    // Wait for the window and check timing, read sequence and contents.
    task automatic verify_window(input logic [31:0] anchor, input int t_acc);
        bit          seen;
        int          n;
        logic [31:0] ea;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.win_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("win_valid_wait", 256'(seen), 256'(1'b1));
        check_output("latency", 256'(cyc - t_acc), 256'(27));
        check_output("read_count", 256'(rd_addr_q.size()), 256'(NUM_PIX));
        n = (rd_addr_q.size() < NUM_PIX) ? rd_addr_q.size() : NUM_PIX;
        for (int k = 0; k < n; k++) begin
            ea = anchor + 32'(k % H_WIN) + 32'((k / H_WIN) * H_IMG);
            check_output($sformatf("rd_addr_%0d", k), 256'(rd_addr_q[k]), 256'(ea));
            check_output($sformatf("rd_cycle_%0d", k), 256'(rd_cyc_q[k]), 256'(t_acc + 1 + k));
        end
        check_output("win_data", 256'(bus.win_data), 256'(exp_window(anchor)));
        check_output("win_anchor", 256'(bus.win_anchor), 256'(anchor));
        check_output($sformatf("frame_last_w%0d", win_idx), 256'(bus.frame_last),
                     256'((win_idx % NUM_WIN) == NUM_WIN - 1));
    endtask

    // Hold the window for some cycles, then take it and check retention.
    task automatic handshake(input logic [31:0] anchor, input int stall);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_output("stall_valid",  256'(bus.win_valid),    256'(1'b1));
            check_output("stall_data",   256'(bus.win_data),     256'(exp_window(anchor)));
            check_output("stall_ready",  256'(bus.anchor_ready), 256'(1'b0));
            check_output("stall_rd_en",  256'(bus.ram_rd_en),    256'(1'b0));
        end
        bus.win_ready = 1'b1;
        @(negedge clk);
        bus.win_ready = 1'b0;
        win_idx++;
        check_output("post_valid",  256'(bus.win_valid),    256'(1'b0));
        check_output("post_retain", 256'(bus.win_data),     256'(exp_window(anchor)));
        check_output("post_ready",  256'(bus.anchor_ready), 256'(1'b1));
        rd_addr_q.delete();
        rd_cyc_q.delete();
    endtask

    // Directed sequence followed by a randomized run across a full frame.
    initial begin
        int          t_acc;
        int          t2;
        logic [31:0] a;
        cyc              = 0;
        tests_run        = 0;
        tests_failed     = 0;
        win_idx          = 0;
        rst              = 1'b1;
        bus.anchor_valid = 1'b0;
        bus.anchor_addr  = '0;
        bus.win_ready    = 1'b0;
        bus.ram_rd_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        apply_stimulus(32'd0, t_acc);
        verify_window(32'd0, t_acc);
        handshake(32'd0, 0);

        apply_stimulus(32'd775, t_acc);
        verify_window(32'd775, t_acc);
        handshake(32'd775, 1);

        apply_stimulus(32'hFFFF_FFF0, t_acc);
        verify_window(32'hFFFF_FFF0, t_acc);
        handshake(32'hFFFF_FFF0, 10);

        bus.anchor_valid = 1'b1;
        bus.anchor_addr  = 32'd0;
        bus.win_ready    = 1'b1;
        t_acc            = cyc;
        @(negedge clk);
        bus.anchor_addr  = 32'd1;
        verify_window(32'd0, t_acc);
        win_idx++;
        rd_addr_q.delete();
        rd_cyc_q.delete();
        @(negedge clk);
        check_output("b2b_ready", 256'(bus.anchor_ready), 256'(1'b1));
        check_output("b2b_valid", 256'(bus.win_valid),    256'(1'b0));
        t2 = cyc;
        @(negedge clk);
        bus.anchor_valid = 1'b0;
        bus.win_ready    = 1'b0;
        verify_window(32'd1, t2);
        handshake(32'd1, 0);

        a = $urandom;
        apply_stimulus(a, t_acc);
        repeat (12) @(negedge clk);
        check_output("k12_rd_en", 256'(bus.ram_rd_en), 256'(1'b1));
        check_output("k12_addr", 256'(bus.ram_rd_addr), 256'(a + 32'd2 + 32'(2*H_IMG)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midreset");
        win_idx = 0;
        rd_addr_q.delete();
        rd_cyc_q.delete();
        @(negedge clk);

        apply_stimulus(32'd31, t_acc);
        verify_window(32'd31, t_acc);
        handshake(32'd31, 0);

        for (int n = 1; n <= NUM_WIN; n++) begin
            a = $urandom;
            apply_stimulus(a, t_acc);
            verify_window(a, t_acc);
            handshake(a, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
